// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the sequencer state encoding, owner IDs and legal read-latency bounds.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant.
// On a tie, the requester that was not granted last wins.
module rr_arbiter2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   // one-hot grant selection
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = (i_last == M1) ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port data memory.
// It runs one transaction at a time: accept, command, latency wait, then a one-cycle response.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [31:0]       m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ready,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [31:0]       m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ready,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int LAT   = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                          ((MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT);
   localparam int CNT_W = 4;

   state_t            r_state;
   state_t            w_next;
   logic              r_last;
   logic              r_owner;
   logic              r_we;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_mem_en;
   logic              r_mem_we;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic              r_err0;
   logic              r_err1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   logic [1:0]        w_gnt;
   logic              w_idle;
   logic              w_acc;
   logic              w_sample;
   logic              w_sel_we;
   logic [31:0]       w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_sel_err;
   logic [DATA_W-1:0] w_resp_data;

   rr_arbiter2 u_arb (
      .i_req  ({m1_req, m0_req}),
      .i_last (r_last),
      .o_gnt  (w_gnt)
   );

   // ready is held low for the whole reset pulse, not just after the edge
   assign w_idle      = (r_state == IDLE) && !rst;
   assign m0_ready    = w_idle & w_gnt[0];
   assign m1_ready    = w_idle & w_gnt[1];
   assign w_acc       = m0_ready | m1_ready;
   assign w_sel_we    = w_gnt[1] ? m1_we    : m0_we;
   assign w_sel_addr  = w_gnt[1] ? m1_addr  : m0_addr;
   assign w_sel_wdata = w_gnt[1] ? m1_wdata : m0_wdata;
   assign w_sel_err   = |w_sel_addr[31:ADDR_W];
   assign w_sample    = (w_next == RESP);
   assign w_resp_data = (r_we || r_err) ? {DATA_W{1'b0}} : mem_rdata;

   // sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // sequencer next-state
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_acc ? CMD : IDLE;
         CMD:     w_next = (LAT > 1) ? WAIT : RESP;
         WAIT:    w_next = (r_cnt == CNT_W'(1)) ? RESP : WAIT;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // transaction capture, grant pointer and latency counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last  <= M1;
         r_owner <= M0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= {ADDR_W{1'b0}};
         r_wdata <= {DATA_W{1'b0}};
         r_cnt   <= {CNT_W{1'b0}};
      end else begin
         if (w_acc) begin
            r_last  <= w_gnt[1];
            r_owner <= w_gnt[1];
            r_we    <= w_sel_we;
            r_err   <= w_sel_err;
            r_addr  <= w_sel_addr[ADDR_W-1:0];
            r_wdata <= w_sel_wdata;
         end
         case (r_state)
            CMD:     r_cnt <= CNT_W'(LAT - 1);
            WAIT:    r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // registered memory command and owner-steered response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_en  <= 1'b0;
         r_mem_we  <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
         r_rdata0  <= {DATA_W{1'b0}};
         r_rdata1  <= {DATA_W{1'b0}};
      end else begin
         r_mem_en  <= w_acc;
         r_mem_we  <= w_acc && w_sel_we && !w_sel_err;
         r_rvalid0 <= w_sample && (r_owner == M0);
         r_rvalid1 <= w_sample && (r_owner == M1);
         r_err0    <= w_sample && (r_owner == M0) && r_err;
         r_err1    <= w_sample && (r_owner == M1) && r_err;
         r_rdata0  <= (w_sample && (r_owner == M0)) ? w_resp_data : {DATA_W{1'b0}};
         r_rdata1  <= (w_sample && (r_owner == M1)) ? w_resp_data : {DATA_W{1'b0}};
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign m0_rvalid = r_rvalid0;
   assign m1_rvalid = r_rvalid1;
   assign m0_rdata  = r_rdata0;
   assign m1_rdata  = r_rdata1;
   assign m0_err    = r_err0;
   assign m1_err    = r_err1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=4.
// Each instance is driven by its own latency-honouring memory and checked against a transaction-level model.
module tb_dmem_arbiter;

   typedef struct {
      int          inst;
      int          owner;
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        m0_req    [2];
   logic        m0_we     [2];
   logic [31:0] m0_addr   [2];
   logic [31:0] m0_wdata  [2];
   logic        m0_ready  [2];
   logic        m0_rvalid [2];
   logic [31:0] m0_rdata  [2];
   logic        m0_err    [2];
   logic        m1_req    [2];
   logic        m1_we     [2];
   logic [31:0] m1_addr   [2];
   logic [31:0] m1_wdata  [2];
   logic        m1_ready  [2];
   logic        m1_rvalid [2];
   logic [31:0] m1_rdata  [2];
   logic        m1_err    [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [5:0]  mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];

   logic [31:0] env_mem [2][64] = '{default: 32'h0};
   int          env_age [2]     = '{default: 0};
   logic [31:0] ref_mem [2][64] = '{default: 32'h0};

   int          cyc     = 0;
   int          ptr     [2] = '{default: 1};
   int          nf      [2] = '{default: 0};
   int          acc_cyc [2] = '{default: -100};
   logic        acc_we  [2];
   logic        acc_err [2];
   logic [5:0]  acc_addr[2];
   logic [31:0] acc_wd  [2];
   exp_t        q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic        mon_en_exp;
   exp_t        mon_e;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MEM_LAT(1)) u_dut0 (
      .clk(clk), .rst(rst[0]),
      .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
      .m0_ready(m0_ready[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]), .m0_err(m0_err[0]),
      .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
      .m1_ready(m1_ready[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]), .m1_err(m1_err[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MEM_LAT(4)) u_dut1 (
      .clk(clk), .rst(rst[1]),
      .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
      .m0_ready(m0_ready[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]), .m0_err(m0_err[1]),
      .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
      .m1_ready(m1_ready[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]), .m1_err(m1_err[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = 32'd64 + 32'($urandom_range(0, 5000));
      else                           a = 32'($urandom_range(0, 15));
      return a;
   endfunction

   // Memory stand-in: writes on command, read data only valid MEM_LAT-1 cycles after the strobe
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (mem_en[i] && mem_we[i]) env_mem[i][mem_addr[i]] <= mem_wdata[i];
         if (mem_en[i])                             env_age[i] <= 1;
         else if (env_age[i] != 0 && env_age[i] < 15) env_age[i] <= env_age[i] + 1;
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         mem_rdata[i] = 32'hDEAD_BEEF;
         if ((mem_en[i] ? 0 : env_age[i]) >= lat(i) - 1) mem_rdata[i] = env_mem[i][mem_addr[i]];
      end
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s inst%0d cyc=%0d: got %h expected %h", nm, i, cyc, act, exp_v);
      end
   endtask

   // Monitor: memory command shape and response scoreboard
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst[i]) begin
            mon_en_exp = (cyc == acc_cyc[i] + 1);
            chk("mem_en", i, 32'(mem_en[i]), 32'(mon_en_exp));
            if (mon_en_exp) begin
               chk("mem_we", i, 32'(mem_we[i]), 32'(acc_we[i] && !acc_err[i]));
               chk("mem_addr", i, 32'(mem_addr[i]), 32'(acc_addr[i]));
               if (acc_we[i]) chk("mem_wdata", i, mem_wdata[i], acc_wd[i]);
            end else begin
               chk("mem_we_quiet", i, 32'(mem_we[i]), 32'd0);
            end
            if (m0_rvalid[i] || m1_rvalid[i]) begin
               if (q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL rvalid_unexpected inst%0d cyc=%0d: got pulse expected none", i, cyc);
               end else begin
                  mon_e = q.pop_front();
                  chk("resp_inst", i, 32'(i), 32'(mon_e.inst));
                  chk("resp_owner", i, 32'({m1_rvalid[i], m0_rvalid[i]}),
                      (mon_e.owner == 1) ? 32'd2 : 32'd1);
                  chk("resp_cycle", i, 32'(cyc), 32'(mon_e.due));
                  chk("resp_rdata", i, m1_rvalid[i] ? m1_rdata[i] : m0_rdata[i], mon_e.rdata);
                  chk("resp_err", i, 32'(m1_rvalid[i] ? m1_err[i] : m0_err[i]), 32'(mon_e.err));
               end
            end
         end
      end
      if (q.size() > 0 && cyc > q[0].due) begin
         n_vec++;
         n_err++;
         $display("FAIL rvalid_missing inst%0d: got none by cyc %0d expected at %0d", q[0].inst, cyc, q[0].due);
         void'(q.pop_front());
      end
   end

   // One cycle: drive, predict the grant from the model, compare ready, log the accept
   task automatic step(input int i,
                       input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       output int won);
      int          win;
      exp_t        e;
      logic        we;
      logic        err;
      logic [31:0] a;
      logic [31:0] d;
      m0_req[i] = r0; m0_we[i] = w0; m0_addr[i] = a0; m0_wdata[i] = d0;
      m1_req[i] = r1; m1_we[i] = w1; m1_addr[i] = a1; m1_wdata[i] = d1;
      #1;
      win = -1;
      if (cyc >= nf[i]) begin
         if (r0 && r1)  win = (ptr[i] == 1) ? 0 : 1;
         else if (r0)   win = 0;
         else if (r1)   win = 1;
         else           win = -1;
      end
      chk("m0_ready", i, 32'(m0_ready[i]), 32'(win == 0));
      chk("m1_ready", i, 32'(m1_ready[i]), 32'(win == 1));
      if (win >= 0) begin
         we  = (win == 1) ? w1 : w0;
         a   = (win == 1) ? a1 : a0;
         d   = (win == 1) ? d1 : d0;
         err = (a >= 32'd64);
         ptr[i]      = win;
         nf[i]       = cyc + lat(i) + 2;
         acc_cyc[i]  = cyc;
         acc_we[i]   = we;
         acc_err[i]  = err;
         acc_addr[i] = a[5:0];
         acc_wd[i]   = d;
         e.inst  = i;
         e.owner = win;
         e.due   = cyc + lat(i) + 1;
         e.err   = err;
         e.rdata = (!we && !err) ? ref_mem[i][a[5:0]] : 32'h0;
         if (we && !err) ref_mem[i][a[5:0]] = d;
         q.push_back(e);
      end
      won = win;
      @(negedge clk);
   endtask

   task automatic idle(input int i, input int n);
      int w;
      for (int k = 0; k < n; k++) step(i, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, w);
   endtask

   task automatic txn(input int i, input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
      int w;
      w = -1;
      for (int k = 0; k < 40 && w < 0; k++) begin
         if (m == 0) step(i, 1'b1, we, a, d, 1'b0, 1'b0, 32'h0, 32'h0, w);
         else        step(i, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, we, a, d, w);
      end
      chk("accept_in_time", i, 32'(w >= 0), 32'd1);
      idle(i, lat(i) + 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int          w;
      logic [31:0] keep;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1;
         m0_req[i] = 1'b1; m0_we[i] = 1'b0; m0_addr[i] = 32'h0; m0_wdata[i] = 32'h0;
         m1_req[i] = 1'b1; m1_we[i] = 1'b0; m1_addr[i] = 32'h0; m1_wdata[i] = 32'h0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_m0_ready", i, 32'(m0_ready[i]), 32'd0);
         chk("rst_m1_ready", i, 32'(m1_ready[i]), 32'd0);
         chk("rst_mem_en", i, 32'(mem_en[i]), 32'd0);
         chk("rst_mem_we", i, 32'(mem_we[i]), 32'd0);
         chk("rst_mem_addr", i, 32'(mem_addr[i]), 32'd0);
         chk("rst_rvalid", i, 32'({m1_rvalid[i], m0_rvalid[i]}), 32'd0);
         chk("rst_rdata", i, m0_rdata[i] | m1_rdata[i], 32'd0);
         m0_req[i] = 1'b0;
         m1_req[i] = 1'b0;
         rst[i]    = 1'b0;
      end
      @(negedge clk);

      for (int i = 0; i < 2; i++) begin
         txn(i, 0, 1'b1, 32'd3, 32'd30);
         txn(i, 0, 1'b0, 32'd3, 32'h0);
         txn(i, 1, 1'b1, 32'd64, 32'hA5A5_0001 + 32'($urandom_range(0, 255)));
         txn(i, 1, 1'b0, 32'd0, 32'h0);
         txn(i, 1, 1'b0, 32'd3, 32'h0);

         // both masters hold req continuously
         for (int k = 0; k < 4 * (lat(i) + 2); k++)
            step(i, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                    1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, w);

         for (int k = 0; k < 300; k++)
            step(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rnd_addr(), $urandom, w);
         idle(i, lat(i) + 3);

         // reset in the command cycle of a write aborts it
         keep = ref_mem[i][5];
         w = -1;
         for (int k = 0; k < 40 && w < 0; k++)
            step(i, 1'b1, 1'b1, 32'd5, 32'hCAFE_0000 + 32'(k), 1'b0, 1'b0, 32'h0, 32'h0, w);
         chk("rst_test_accept", i, 32'(w), 32'd0);
         #2;
         rst[i] = 1'b1;
         #1;
         chk("abort_mem_en", i, 32'(mem_en[i]), 32'd0);
         chk("abort_mem_we", i, 32'(mem_we[i]), 32'd0);
         chk("abort_ready", i, 32'(m0_ready[i]), 32'd0);
         m0_req[i] = 1'b0;
         m1_req[i] = 1'b0;
         q.delete();
         ref_mem[i][5] = keep;
         acc_cyc[i] = -100;
         ptr[i] = 1;
         nf[i] = 0;
         @(negedge clk);
         #2;
         rst[i] = 1'b0;
         @(negedge clk);
         w = -1;
         for (int k = 0; k < 40 && w < 0; k++)
            step(i, 1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 1'b0, 32'd2, 32'h0, w);
         chk("tie_after_reset", i, 32'(w), 32'd0);
         idle(i, lat(i) + 2);
         txn(i, 1, 1'b0, 32'd5, 32'h0);
         idle(i, lat(i) + 3);
      end

      chk("queue_drained", 0, 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
